// File: rtl/tagged_pkg.sv
// Shared helpers for the tagged stream stages: index width sizing and
// round-robin pointer increment.
package tagged_pkg;

  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rr_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/tagged_skid_buffer.sv
// Two-entry registered ready/valid slice; one cycle latency, full throughput.
// in_ready is "not full" only, so there is no combinational path from out_ready.
module tagged_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] ent0;
  logic [W-1:0] ent1;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = ent0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // ent0 is always the head; ent1 only holds the second beat while full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 2'd0;
      ent0  <= '0;
      ent1  <= '0;
    end else begin
      unique case (count)
        2'd0: begin
          if (push) begin
            ent0  <= in_data;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            ent0 <= in_data;
          end else if (push) begin
            ent1  <= in_data;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            ent0  <= ent1;
            count <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/tagged_arbiter.sv
// Round-robin, packet-locked merge of NUM_STREAMS tagged streams; one cycle latency via skid buffer.
// Only the granted input sees ready (buffer not full). TAGGED_ARBITER_SRC_ID_EN adds out_src.
module tagged_arbiter
  import tagged_pkg::*;
#(
  parameter int NUM_STREAMS  = 2,
  parameter int LOCK_ON_LAST = 1,
  parameter int DATA_W       = 32,
  parameter int TAG_W        = 4,
  parameter int KEEP_W       = DATA_W / 8,
  localparam int SRC_W       = src_w(NUM_STREAMS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_STREAMS-1:0]        in_valid,
  output logic [NUM_STREAMS-1:0]        in_ready,
  input  logic [NUM_STREAMS*DATA_W-1:0] in_data,
  input  logic [NUM_STREAMS*TAG_W-1:0]  in_tag,
  input  logic [NUM_STREAMS*KEEP_W-1:0] in_keep,
  input  logic [NUM_STREAMS-1:0]        in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [TAG_W-1:0]              out_tag,
  output logic [KEEP_W-1:0]             out_keep,
  output logic                          out_last
`ifdef TAGGED_ARBITER_SRC_ID_EN
  ,
  output logic [SRC_W-1:0]              out_src
`endif
);

`ifdef TAGGED_ARBITER_SRC_ID_EN
  localparam int PAY_W = SRC_W + DATA_W + TAG_W + KEEP_W + 1;
`else
  localparam int PAY_W = DATA_W + TAG_W + KEEP_W + 1;
`endif

  logic             lock;
  logic [SRC_W-1:0] lock_idx;
  logic [SRC_W-1:0] rr_ptr;
  logic             gnt_vld;
  logic [SRC_W-1:0] gnt_idx;
  logic             can_accept;
  logic             accept;
  logic             sel_valid;
  logic [DATA_W-1:0] sel_data;
  logic [TAG_W-1:0]  sel_tag;
  logic [KEEP_W-1:0] sel_keep;
  logic              sel_last;
  logic [PAY_W-1:0]  pay_in;
  logic [PAY_W-1:0]  pay_out;

  // Scan downward in offset so the requester closest to rr_ptr wins.
  always_comb begin
    int sum;
    logic [SRC_W-1:0] idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    sum     = 0;
    idx     = '0;
    if (lock) begin
      gnt_vld = 1'b1;
      gnt_idx = lock_idx;
    end else begin
      for (int k = NUM_STREAMS - 1; k >= 0; k--) begin
        sum = int'(rr_ptr) + k;
        if (sum >= NUM_STREAMS) sum = sum - NUM_STREAMS;
        idx = SRC_W'(sum);
        if (in_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = idx;
        end
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_tag   = '0;
    sel_keep  = '0;
    sel_last  = 1'b0;
    in_ready  = '0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      if (gnt_idx == SRC_W'(i)) begin
        sel_valid   = in_valid[i];
        sel_data    = in_data[i*DATA_W +: DATA_W];
        sel_tag     = in_tag[i*TAG_W +: TAG_W];
        sel_keep    = in_keep[i*KEEP_W +: KEEP_W];
        sel_last    = in_last[i];
        in_ready[i] = rst_n && gnt_vld && can_accept;
      end
    end
  end

  assign accept = rst_n && gnt_vld && can_accept && sel_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock     <= 1'b0;
      lock_idx <= '0;
      rr_ptr   <= '0;
    end else if (accept) begin
      if (LOCK_ON_LAST != 0 && !sel_last) begin
        lock     <= 1'b1;
        lock_idx <= gnt_idx;
      end else begin
        lock   <= 1'b0;
        rr_ptr <= SRC_W'(rr_inc(int'(gnt_idx), NUM_STREAMS));
      end
    end
  end

`ifdef TAGGED_ARBITER_SRC_ID_EN
  assign pay_in = {gnt_idx, sel_data, sel_tag, sel_keep, sel_last};
  assign {out_src, out_data, out_tag, out_keep, out_last} = pay_out;
`else
  assign pay_in = {sel_data, sel_tag, sel_keep, sel_last};
  assign {out_data, out_tag, out_keep, out_last} = pay_out;
`endif

  tagged_skid_buffer #(.W(PAY_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .in_ready  (can_accept),
    .in_data   (pay_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pay_out)
  );

endmodule

// File: tb/tb_tagged_arbiter.sv
// Directed bench for tagged_arbiter with four streams: round-robin order, packet lock,
// mid-packet stall, output backpressure and mid-packet reset.
module tb_tagged_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int KW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N*DW-1:0] in_data;
  logic [N*TW-1:0] in_tag;
  logic [N*KW-1:0] in_keep;
  logic [N-1:0]    in_last;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [TW-1:0]   out_tag;
  logic [KW-1:0]   out_keep;
  logic            out_last;
`ifdef TAGGED_ARBITER_SRC_ID_EN
  logic [1:0]      out_src;
`endif

  logic [DW-1:0] d  [N];
  logic [TW-1:0] tg [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    in_data = '0;
    in_tag  = '0;
    in_keep = '0;
    for (int i = 0; i < N; i++) begin
      in_data[i*DW +: DW] = d[i];
      in_tag[i*TW +: TW]  = tg[i];
      in_keep[i*KW +: KW] = 4'hF;
    end
  end

  tagged_arbiter #(
    .NUM_STREAMS  (N),
    .LOCK_ON_LAST (1),
    .DATA_W       (DW),
    .TAG_W        (TW),
    .KEEP_W       (KW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .in_keep   (in_keep),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_keep  (out_keep),
    .out_last  (out_last)
`ifdef TAGGED_ARBITER_SRC_ID_EN
    ,
    .out_src   (out_src)
`endif
  );

  function automatic logic [31:0] mk(input int s, input int b);
    return (32'(s) << 16) | 32'(b);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_beat(input int s, input int b, input logic l);
    d[s]       = mk(s, b);
    tg[s]      = TW'(s);
    in_last[s] = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input int s, input int b, input logic l);
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("out_tag", 32'(out_tag), 32'(s));
    chk("out_data", out_data, mk(s, b));
    chk("out_last", 32'(out_last), 32'(l));
`ifdef TAGGED_ARBITER_SRC_ID_EN
    chk("out_src", 32'(out_src), 32'(s));
`endif
  endtask

  initial begin
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_beat(i, 0, 1'b1);

    // reset with requests pending
    in_valid = 4'hF;
    rst_n    = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rr0_ready", 32'(in_ready), 32'b0001);

    // all valid, single-beat packets: source order 0,1,2,3,0
    tick(); chk_out(0, 0, 1'b1); chk("keep", 32'(out_keep), 32'hF);
    chk("rr1_ready", 32'(in_ready), 32'b0010);
    tick(); chk_out(1, 0, 1'b1);
    tick(); chk_out(2, 0, 1'b1);
    tick(); chk_out(3, 0, 1'b1);
    tick(); chk_out(0, 0, 1'b1);
    in_valid = '0;
    tick(); chk("drain1", 32'(out_valid), 32'd0);

    // 3-beat packet on in[1] while in[2] waits
    set_beat(1, 0, 1'b0);
    set_beat(2, 0, 1'b1);
    in_valid = 4'b0110;
    #1; chk("lock_ready0", 32'(in_ready), 32'b0010);
    tick(); chk_out(1, 0, 1'b0);
    set_beat(1, 1, 1'b0);
    #1; chk("lock_ready1", 32'(in_ready), 32'b0010);
    tick(); chk_out(1, 1, 1'b0);
    set_beat(1, 2, 1'b1);
    #1; chk("lock_ready2", 32'(in_ready), 32'b0010);
    tick(); chk_out(1, 2, 1'b1);
    in_valid = 4'b0100;
    #1; chk("unlock_ready", 32'(in_ready), 32'b0100);
    tick(); chk_out(2, 0, 1'b1);
    in_valid = '0;
    tick(); chk("drain2", 32'(out_valid), 32'd0);

    // locked in[0] stalls mid-packet while in[3] waits
    set_beat(0, 0, 1'b0);
    set_beat(3, 0, 1'b1);
    in_valid = 4'b0001;
    tick(); chk_out(0, 0, 1'b0);
    in_valid = 4'b1000;
    #1; chk("stall_ready", 32'(in_ready), 32'b0001);
    tick(); chk("stall_vld1", 32'(out_valid), 32'd0);
    tick(); chk("stall_vld2", 32'(out_valid), 32'd0);
    set_beat(0, 1, 1'b1);
    in_valid = 4'b1001;
    #1; chk("resume_ready", 32'(in_ready), 32'b0001);
    tick(); chk_out(0, 1, 1'b1);
    in_valid = 4'b1000;
    #1; chk("after_ready", 32'(in_ready), 32'b1000);
    tick(); chk_out(3, 0, 1'b1);
    in_valid = '0;
    tick(); chk("drain3", 32'(out_valid), 32'd0);

    // output stalled for 5 cycles under full load (rr_ptr wrapped to 0)
    for (int i = 0; i < N; i++) set_beat(i, 0, 1'b1);
    in_valid  = 4'hF;
    out_ready = 1'b0;
    tick();
    tick();
    chk("full_ready_a", 32'(in_ready), 32'd0);
    tick();
    tick();
    tick();
    chk("full_ready_b", 32'(in_ready), 32'd0);
    chk_out(0, 0, 1'b1);
    out_ready = 1'b1;
    tick(); chk_out(1, 0, 1'b1);
    tick(); chk_out(2, 0, 1'b1);
    tick(); chk_out(3, 0, 1'b1);
    in_valid = '0;
    tick(); chk("drain4", 32'(out_valid), 32'd0);

    // reset during beat 2 of a 4-beat packet on in[2]
    set_beat(2, 0, 1'b0);
    in_valid = 4'b0100;
    tick(); chk_out(2, 0, 1'b0);
    set_beat(2, 1, 1'b0);
    set_beat(1, 0, 1'b1);
    in_valid = 4'b0110;
    rst_n    = 1'b0;
    #1; chk("midrst_ready", 32'(in_ready), 32'd0);
    tick(); chk("midrst_vld", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    #1; chk("postrst_ready", 32'(in_ready), 32'b0010);
    tick(); chk_out(1, 0, 1'b1);
    in_valid = '0;
    tick(); chk("drain5", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tagged_arbiter.md
Name: tagged_arbiter

Overview:
- Merges NUM_STREAMS tagged input streams into one tagged output stream.
- Arbitration is round-robin and packet-locked: a granted input keeps the output until its beat with last=1 is accepted.
- Sits downstream of the tagged duplicator fan-out. It re-joins per-stream processing results into a single stream.
- Output is registered through a 2-entry skid buffer, giving full throughput and no combinational ready/valid path from out to in.

Parameters:
- NUM_STREAMS, 2, number of input streams; legal range 2..16.
- LOCK_ON_LAST, 1, 1 = grant held until a last beat is accepted; 0 = re-arbitrate every beat.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- in  tagged_i.s array  NUM_STREAMS  input streams; fields data, tag, keep, last, valid, ready; data_t and TAG_WIDTH set by the interface
- out  tagged_i.m  1  merged output stream, same data_t and TAG_WIDTH as in

Behaviour:
- Reset (rst_n=0 at posedge): out.valid=0, skid buffer empty, lock=0, rr_ptr=0, all in[i].ready=0 during the reset cycle.
- Latency: an input beat accepted in cycle t appears on out in cycle t+1. out.data/tag/keep/last are driven only from registers.
- Skid buffer:
  - Two entries.
  - can_accept = buffer not full.
  - out.valid = buffer not empty.
  - Pop occurs on out.valid && out.ready. Push and pop can happen in the same cycle.
  - Sustained throughput is 1 beat/cycle while out.ready=1.
- Arbitration (combinational, when lock=0):
  - Scan in[rr_ptr], in[rr_ptr+1], ... modulo NUM_STREAMS.
  - The first input with valid=1 is granted.
  - If no input is valid, there is no grant.
- Grant when lock=1: the grant is lock_idx, regardless of other valids.
- in[g].ready = can_accept for the granted index g. All other in[i].ready=0. in.ready never depends on out.ready combinationally.
- Accept on in[g].valid && in[g].ready:
  - data/tag/keep/last are copied unmodified into the buffer.
  - If LOCK_ON_LAST=1 and last=0: lock<=1, lock_idx<=g.
  - If last=1: lock<=0, rr_ptr<=(g+1) mod NUM_STREAMS.
  - If LOCK_ON_LAST=0: lock stays 0 and rr_ptr<=(g+1) mod NUM_STREAMS on every accepted beat.
- Locked input drops valid mid-packet: lock is held and the output idles. Other inputs are not granted.
- Buffer full: all in.ready=0 and lock/rr_ptr are unchanged.
- Single valid requester: granted every cycle, no bubbles.
- Reset mid-packet: lock is cleared and buffered beats are discarded. Upstream is responsible for re-framing.
- rr_ptr wrap: from NUM_STREAMS-1 it wraps to 0. rr_ptr and lock_idx are $clog2(NUM_STREAMS) bits wide.

Optional Feature:
- Macro: TAGGED_ARBITER_SRC_ID_EN
- Defined:
  - An extra port out_src, output, $clog2(NUM_STREAMS) bits, carries the source index of the current out beat.
  - The index is stored per buffer entry.
- Undefined: the port and its storage do not exist. Behaviour is otherwise identical.

Decomposition:
- Shared package tagged_pkg:
  - function for the round-robin index increment
  - SRC_W localparam helper ($clog2 with a minimum of 1)
- Sub-module tagged_skid_buffer:
  - 2-entry registered ready/valid slice over data, tag, keep, last and optional src.
  - Reusable by other tagged stages.
- Arbiter logic stays in tagged_arbiter.

Test Plan:
- NUM_STREAMS=4, all inputs valid with 1-beat packets (last=1), out.ready=1 -> out tags in source order 0,1,2,3,0,... with 1 beat/cycle after a 1-cycle latency.
- in[1] sends a 3-beat packet (last on beat 3) while in[2] is valid -> three in[1] beats appear contiguously, then in[2]; in[2].ready=0 during the lock.
- Locked in[0] drops valid for 2 cycles mid-packet while in[3] is valid -> out.valid=0 for those cycles; in[3] is not granted until in[0] delivers last.
- out.ready=0 for 5 cycles under full load -> exactly 2 beats buffered, all in.ready=0, no beat lost or duplicated; order is preserved on release.
- Assert rst_n=0 during the 2nd beat of a 4-beat packet from in[2] -> next cycle out.valid=0, lock=0, rr_ptr=0; the first post-reset grant goes to the lowest valid index.
- TAGGED_ARBITER_SRC_ID_EN defined, round-robin traffic -> out_src sequence 0,1,2,3 matches the originating inputs beat for beat.
